// File: rtl/dsc_pkg.sv
// dsc_pkg: shared types and constants for the DSC decoder front end.
//   dsc_unpack_cfg_t : slice geometry latched by the unpacker at frame start
//   unp_state_e      : unpacker sequencing states
//   KEEP_1..KEEP_4   : byte-keep patterns for 1..4 valid lanes (lane 0 first)
package dsc_pkg;

  localparam int DSC_CNT_W = 16;
  localparam int DSC_SLC_W = 8;

  // Field widths follow DSC_CNT_W / DSC_SLC_W; the unpacker parameters
  // default to the same values and must be kept in step with them.
  typedef struct packed {
    logic [DSC_CNT_W-1:0] chunk_size;
    logic [DSC_CNT_W-1:0] slice_height;
    logic [DSC_SLC_W-1:0] slices;
  } dsc_unpack_cfg_t;

  typedef enum logic [1:0] {
    UNP_IDLE  = 2'd0,
    UNP_RUN   = 2'd1,
    UNP_DRAIN = 2'd2
  } unp_state_e;

  localparam logic [3:0] KEEP_1 = 4'b0001;
  localparam logic [3:0] KEEP_2 = 4'b0011;
  localparam logic [3:0] KEEP_3 = 4'b0111;
  localparam logic [3:0] KEEP_4 = 4'b1111;

  function automatic logic [3:0] lanes_to_keep(input logic [2:0] lanes);
    logic [3:0] keep;
    case (lanes)
      3'd1:    keep = KEEP_1;
      3'd2:    keep = KEEP_2;
      3'd3:    keep = KEEP_3;
      3'd4:    keep = KEEP_4;
      default: keep = 4'b0000;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/dsc_byte_packer.sv
// dsc_byte_packer: collects accepted bytes little-endian into one 32-bit word.
//   clk, rst_n   : clock, synchronous active-low reset
//   acc          : a byte is accepted this cycle (in_byte valid)
//   in_byte      : accepted byte
//   byte_last    : accepted byte is the final byte of its chunk
//   byte_eos     : accepted byte is the final byte of a slice
//   xfer         : pack contents move to the output register this cycle
//   pk_data      : packed bytes, unused lanes zero
//   pk_keep      : lane keep derived from the lane count
//   pk_full      : word ready to hand over (4 bytes or chunk end)
//   pk_last      : word closes a chunk
//   pk_eos       : word closes a slice
module dsc_byte_packer
  import dsc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc,
  input  logic [7:0]  in_byte,
  input  logic        byte_last,
  input  logic        byte_eos,
  input  logic        xfer,
  output logic [31:0] pk_data,
  output logic [3:0]  pk_keep,
  output logic        pk_full,
  output logic        pk_last,
  output logic        pk_eos
);

  logic [2:0]  lanes_q, lanes_d;
  logic [31:0] data_q, data_d;
  logic        full_q, full_d;
  logic        last_q, last_d;
  logic        eos_q, eos_d;

  logic [2:0]  base_lanes;

  always_comb begin
    // A handover empties the pack first, so a byte accepted in the same
    // cycle lands in lane 0 of a fresh word.
    base_lanes = xfer ? 3'd0 : lanes_q;
    lanes_d    = base_lanes;
    data_d     = xfer ? 32'h0 : data_q;
    full_d     = xfer ? 1'b0 : full_q;
    last_d     = xfer ? 1'b0 : last_q;
    eos_d      = xfer ? 1'b0 : eos_q;
    if (acc) begin
      case (base_lanes[1:0])
        2'd0:    data_d[7:0]   = in_byte;
        2'd1:    data_d[15:8]  = in_byte;
        2'd2:    data_d[23:16] = in_byte;
        default: data_d[31:24] = in_byte;
      endcase
      lanes_d = base_lanes + 3'd1;
      // Chunk end closes the word early so chunks never share a word.
      if ((lanes_d == 3'd4) || byte_last) begin
        full_d = 1'b1;
        last_d = byte_last;
        eos_d  = byte_eos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lanes_q <= 3'd0;
      data_q  <= 32'h0;
      full_q  <= 1'b0;
      last_q  <= 1'b0;
      eos_q   <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      data_q  <= data_d;
      full_q  <= full_d;
      last_q  <= last_d;
      eos_q   <= eos_d;
    end
  end

  assign pk_data = data_q;
  assign pk_keep = lanes_to_keep(lanes_q);
  assign pk_full = full_q;
  assign pk_last = last_q;
  assign pk_eos  = eos_q;

endmodule

// File: rtl/dsc_cmpr_unpacker.sv
// dsc_cmpr_unpacker: splits the compressed DSC byte stream into slice-line
// chunks and packs each chunk into 32-bit words for the decoder core.
//   clk, rst_n        : clock, synchronous active-low reset
//   cfg_chunk_size    : bytes per slice-line chunk (latched at start)
//   cfg_slice_height  : chunks per slice (latched at start)
//   cfg_slices        : slices per frame (latched at start)
//   start             : frame start pulse, ignored while busy
//   busy, done        : frame in progress / one-cycle frame-complete pulse
//   err_cfg           : one-cycle pulse when start sees a zero cfg field
//   in_valid/in_data/in_ready      : 8-bit byte stream in
//   out_valid/out_data/out_keep/out_last/out_eos/out_sof/out_ready : word stream out
//
// state     | meaning
// ----------+-----------------------------------------------------------
// UNP_IDLE  | waiting for start; cfg checked, latched on a good start
// UNP_RUN   | accepting bytes, counting bytes/lines/slices
// UNP_DRAIN | all bytes taken; flushing pack and output register
module dsc_cmpr_unpacker
  import dsc_pkg::*;
#(
  parameter int CNT_W = DSC_CNT_W,
  parameter int SLC_W = DSC_SLC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_chunk_size,
  input  logic [CNT_W-1:0] cfg_slice_height,
  input  logic [SLC_W-1:0] cfg_slices,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [3:0]       out_keep,
  output logic             out_last,
  output logic             out_eos,
  output logic             out_sof,
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SLC_W-1:0] SLC_ONE = {{(SLC_W-1){1'b0}}, 1'b1};

  unp_state_e      state_q, state_d;
  dsc_unpack_cfg_t cfg_q, cfg_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [SLC_W-1:0] slice_cnt_q, slice_cnt_d;
  logic             sof_pend_q, sof_pend_d;
  logic             done_q, done_d;
  logic             err_cfg_q, err_cfg_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [3:0]       out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic             out_eos_q, out_eos_d;
  logic             out_sof_q, out_sof_d;

  logic [31:0] pk_data;
  logic [3:0]  pk_keep;
  logic        pk_full, pk_last, pk_eos;

  logic acc, xfer;
  logic byte_last, line_last, slice_last;
  logic cfg_bad;

  assign xfer     = pk_full && (!out_valid_q || out_ready);
  assign in_ready = (state_q == UNP_RUN) && (!pk_full || xfer);
  assign acc      = in_valid && in_ready;

  assign byte_last  = (byte_cnt_q  == (cfg_q.chunk_size   - CNT_ONE));
  assign line_last  = (line_cnt_q  == (cfg_q.slice_height - CNT_ONE));
  assign slice_last = (slice_cnt_q == (cfg_q.slices       - SLC_ONE));

  assign cfg_bad = (cfg_chunk_size == '0) || (cfg_slice_height == '0) ||
                   (cfg_slices == '0);

  dsc_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc       (acc),
    .in_byte   (in_data),
    .byte_last (byte_last),
    .byte_eos  (byte_last && line_last),
    .xfer      (xfer),
    .pk_data   (pk_data),
    .pk_keep   (pk_keep),
    .pk_full   (pk_full),
    .pk_last   (pk_last),
    .pk_eos    (pk_eos)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    byte_cnt_d  = byte_cnt_q;
    line_cnt_d  = line_cnt_q;
    slice_cnt_d = slice_cnt_q;
    sof_pend_d  = sof_pend_q;
    done_d      = 1'b0;
    err_cfg_d   = 1'b0;

    case (state_q)
      UNP_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_cfg_d = 1'b1;
          end else begin
            cfg_d.chunk_size   = cfg_chunk_size;
            cfg_d.slice_height = cfg_slice_height;
            cfg_d.slices       = cfg_slices;
            byte_cnt_d  = '0;
            line_cnt_d  = '0;
            slice_cnt_d = '0;
            sof_pend_d  = 1'b1;
            state_d     = UNP_RUN;
          end
        end
      end
      UNP_RUN: begin
        if (acc) begin
          if (byte_last) begin
            byte_cnt_d = '0;
            if (line_last) begin
              line_cnt_d = '0;
              if (slice_last) begin
                slice_cnt_d = '0;
                state_d     = UNP_DRAIN;
              end else begin
                slice_cnt_d = slice_cnt_q + SLC_ONE;
              end
            end else begin
              line_cnt_d = line_cnt_q + CNT_ONE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_ONE;
          end
        end
      end
      UNP_DRAIN: begin
        if (!pk_full && !out_valid_q) begin
          done_d  = 1'b1;
          state_d = UNP_IDLE;
        end
      end
      default: state_d = UNP_IDLE;
    endcase
  end

  // Output register: loads on handover, clears once taken, holds on stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_eos_d   = out_eos_q;
    out_sof_d   = out_sof_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = pk_data;
      out_keep_d  = pk_keep;
      out_last_d  = pk_last;
      out_eos_d   = pk_eos;
      out_sof_d   = sof_pend_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_data_d  = 32'h0;
      out_keep_d  = 4'h0;
      out_last_d  = 1'b0;
      out_eos_d   = 1'b0;
      out_sof_d   = 1'b0;
    end
  end

  // sof is consumed by the first handover of the frame; the packer is
  // always empty in IDLE, so this never collides with the start load.
  logic sof_pend_nx;
  assign sof_pend_nx = xfer ? 1'b0 : sof_pend_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= UNP_IDLE;
      cfg_q       <= '0;
      byte_cnt_q  <= '0;
      line_cnt_q  <= '0;
      slice_cnt_q <= '0;
      sof_pend_q  <= 1'b0;
      done_q      <= 1'b0;
      err_cfg_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      out_keep_q  <= 4'h0;
      out_last_q  <= 1'b0;
      out_eos_q   <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      byte_cnt_q  <= byte_cnt_d;
      line_cnt_q  <= line_cnt_d;
      slice_cnt_q <= slice_cnt_d;
      sof_pend_q  <= sof_pend_nx;
      done_q      <= done_d;
      err_cfg_q   <= err_cfg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_eos_q   <= out_eos_d;
      out_sof_q   <= out_sof_d;
    end
  end

  assign busy      = (state_q != UNP_IDLE);
  assign done      = done_q;
  assign err_cfg   = err_cfg_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_eos   = out_eos_q;
  assign out_sof   = out_sof_q;

endmodule
